// File: rtl/simd_loop_iter_ctrl.sv
// Nested-loop iteration controller: per-group iteration tables, IDLE/ARM/RUN sequencing,
// and a combinational step/wrap vector. Zero latency from step to iter_done; stall freezes RUN.
module simd_loop_iter_ctrl #(
  parameter int LOOP_ID_W      = 5,
  parameter int GROUP_ID_W     = 2,
  parameter int ITER_W         = 16,
  parameter int GROUP_ENABLED  = 1,
  parameter int NUM_MAX_LOOPS  = 1 << LOOP_ID_W,
  parameter int NUM_MAX_GROUPS = 1 << GROUP_ID_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   block_done,
  input  logic                   cfg_loop_iter_v,
  input  logic [ITER_W-1:0]      cfg_loop_iter,
  input  logic [GROUP_ID_W-1:0]  cfg_loop_group_id,
  input  logic [GROUP_ID_W-1:0]  loop_group_id,
  output logic [NUM_MAX_LOOPS:0] iter_done,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  state_e                               state_q, state_d;
  logic [GROUP_ID_W-1:0]                grp_q, grp_d;
  logic [NUM_MAX_LOOPS-1:0][ITER_W-1:0] idx_q, idx_d;
  logic [ITER_W-1:0]                    tbl_q [NUM_MAX_GROUPS][NUM_MAX_LOOPS];
  logic [LOOP_ID_W-1:0]                 wptr_q [NUM_MAX_GROUPS];
  logic                                 done_q;

  logic [GROUP_ID_W-1:0]  cfg_grp;
  logic [GROUP_ID_W-1:0]  start_grp;
  logic [NUM_MAX_LOOPS:0] sfx;
  logic                   step;
  logic                   cfg_we;

  assign cfg_grp   = (GROUP_ENABLED != 0) ? cfg_loop_group_id : '0;
  assign start_grp = (GROUP_ENABLED != 0) ? loop_group_id : '0;
  assign step      = (state_q == S_RUN) && !stall;
  assign cfg_we    = cfg_loop_iter_v && (state_q == S_IDLE);

  // sfx[i]: loop i and every loop inside it sit at their final index; sfx[top] is always 1.
  always_comb begin
    logic acc;
    acc = 1'b1;
    sfx = '0;
    sfx[NUM_MAX_LOOPS] = 1'b1;
    for (int i = NUM_MAX_LOOPS - 1; i >= 0; i--) begin
      acc    = acc && (idx_q[i] == tbl_q[grp_q][i]);
      sfx[i] = acc;
    end
  end

  always_comb begin
    idx_d = idx_q;
    if (state_q == S_ARM) begin
      idx_d = '0;
    end else if (step) begin
      for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
        if (sfx[i]) begin
          idx_d[i] = '0;
        end else if (sfx[i+1]) begin
          idx_d[i] = idx_q[i] + ITER_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ARM;
          grp_d   = start_grp;
        end
      end
      S_ARM:   state_d = S_RUN;
      S_RUN:   if (step && sfx[0]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grp_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      for (int g = 0; g < NUM_MAX_GROUPS; g++) begin
        wptr_q[g] <= '0;
        for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
          tbl_q[g][i] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      idx_q   <= idx_d;
      done_q  <= step && sfx[0];
      if (cfg_we) begin
        tbl_q[cfg_grp][wptr_q[cfg_grp]] <= cfg_loop_iter;
        wptr_q[cfg_grp] <= (wptr_q[cfg_grp] == LOOP_ID_W'(NUM_MAX_LOOPS - 1)) ?
                           '0 : wptr_q[cfg_grp] + LOOP_ID_W'(1);
      end
      // Later assignment wins, so a same-cycle write uses the old pointer and it still ends at 0.
      if (block_done) begin
        for (int g = 0; g < NUM_MAX_GROUPS; g++) begin
          wptr_q[g] <= '0;
        end
      end
    end
  end

  // Outputs are masked by reset so they drop in the very cycle reset is sampled.
  assign iter_done = (step && !reset) ? sfx : '0;
  assign busy      = (state_q != S_IDLE) && !reset;
  assign done      = done_q;

endmodule

// File: doc/simd_loop_iter_ctrl.md
SIMD_LOOP_ITER_CTRL -- requirements
Module: simd_loop_iter_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- LOOP_ID_W, 5, loop index width.
- GROUP_ID_W, 2, group index width.
- ITER_W, 16, iteration-count field width.
- GROUP_ENABLED, 1, 0 forces every group id to 0.
- NUM_MAX_LOOPS, 1<<LOOP_ID_W, loop-nest depth.
- NUM_MAX_GROUPS, 1<<GROUP_ID_W, number of iteration tables.
REQ-002 One clock; reset is synchronous and active-high. Ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, single-cycle launch pulse.
- stall, in, 1, freeze stepping.
- block_done, in, 1, clear per-group config write pointers.
- cfg_loop_iter_v, in, 1, config write strobe.
- cfg_loop_iter, in, ITER_W, iterations minus 1.
- cfg_loop_group_id, in, GROUP_ID_W, group receiving the config write.
- loop_group_id, in, GROUP_ID_W, group whose table is used at launch.
- iter_done, out, NUM_MAX_LOOPS+1, step/wrap vector.
- busy, out, 1, launch in progress.
- done, out, 1, single-cycle completion pulse.

Function
REQ-003 Per group g, a table holds iteration counts cnt[g][0..NUM_MAX_LOOPS-1]. Loop 0 is outermost; loop NUM_MAX_LOOPS-1 is innermost.
REQ-004 On cfg_loop_iter_v, write cfg_loop_iter into table[cfg_loop_group_id] at entry wptr[cfg_loop_group_id], then increment that wptr by 1 (modulo NUM_MAX_LOOPS).
REQ-005 block_done clears every wptr to 0; tables are not changed. If block_done and cfg_loop_iter_v occur in the same cycle, the write uses the old pointer and the pointer ends at 0.
REQ-006 Config writes while busy=1 are dropped.
REQ-007 Loop i executes cnt+1 iterations. An entry value of 0 (including the reset value) means one iteration, so that loop is always terminal.
REQ-008 States and transitions:
- IDLE -> ARM on start.
- ARM -> RUN unconditionally after 1 cycle.
- RUN -> IDLE in the cycle iter_done[0] is asserted.
- start is ignored outside IDLE.
REQ-009 The group id is latched on start. The RUN table is table[latched id]. Changing loop_group_id mid-run has no effect.
REQ-010 In ARM, all per-loop counters idx[i] load 0.
REQ-011 step = (state==RUN) && ~stall.
REQ-012 iter_done[NUM_MAX_LOOPS] = step.
REQ-013 For 0 <= i < NUM_MAX_LOOPS, iter_done[i] = step AND (idx[j]==cnt[j] for all j >= i). iter_done is combinational from registered state; latency from step to iter_done is 0.
REQ-014 On step, the innermost non-terminal loop increments. Every loop inner to it resets to 0.
REQ-015 iter_done[0] asserts exactly once per launch, on the final step. done is a registered copy of iter_done[0], asserted 1 cycle later.
REQ-016 busy = (state != IDLE).
REQ-017 While stall=1, iter_done is all-zero and idx and state hold. stall has no effect in IDLE or ARM.
REQ-018 Total steps per launch = product over i of (cnt[i]+1). The counters never overflow: idx[i] <= cnt[i] at all times.

Reset
REQ-019 reset returns the block to IDLE, including mid-run, and clears the following registers to 0: all table entries, all wptr, all idx, the latched group, and done.
REQ-020 After reset, iter_done=0 and busy=0 in the same cycle reset is sampled and onward. No iter_done bit asserts until a new start.

Verification (bench uses LOOP_ID_W=2, so 4 loops)
REQ-021 Scenario: write group 0 entries 1, 2, 0, 0; start at T0.
- busy=1 from T1.
- iter_done[4] high on cycles T2..T7.
- iter_done[3] and iter_done[2] equal iter_done[4].
- iter_done[1] high at T4 and T7.
- iter_done[0] high at T7 only; done=1 at T8; busy=0 at T8.
REQ-022 Scenario: same as REQ-021 with stall=1 on T3..T4. There are 6 step cycles in total, ending at T9. iter_done=0 during T3..T4; iter_done[0] at T9.
REQ-023 Scenario: group 1 holds entries 3, 0, 0, 0; group 0 holds all zeros; loop_group_id=1 at start, then switch it to 0 at T3. Exactly 4 steps occur, iter_done[0] at T5.
REQ-024 Scenario: all-zero table. start at T0 gives a single step at T2 with all 5 iter_done bits high; done at T3.
REQ-025 Scenario: assert reset at T4 of the REQ-021 run. iter_done=0 and busy=0 from T4 onward. A subsequent start yields 1 step, because the tables were cleared.
REQ-026 Scenario: write 2 entries to group 0, pulse block_done, then write 5. Entry 0 = 5, entry 1 = old value, wptr[0] = 1. A start pulse while busy does not extend the run.
